// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and default sizes for the multiply/divide unit
package muldiv_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: pipeline-to-muldiv request and HI/LO result bundle
interface muldiv_if import muldiv_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] OperandB;
  logic             HiWrite;
  logic             LoWrite;
  logic [WIDTH-1:0] WriteData;
  logic             ReadHiLo;
  logic [WIDTH-1:0] ALUhi;
  logic [WIDTH-1:0] ALUlo;
  logic             Busy;
  logic             Done;
  logic             DivByZero;
  logic             Stall;
  modport master (output Start, Op, OperandA, OperandB, HiWrite, LoWrite, WriteData, ReadHiLo,
                  input ALUhi, ALUlo, Busy, Done, DivByZero, Stall);
  modport slave (input Start, Op, OperandA, OperandB, HiWrite, LoWrite, WriteData, ReadHiLo,
                 output ALUhi, ALUlo, Busy, Done, DivByZero, Stall);
endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negate
module muldiv_sign_fix #(parameter int W = 32) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);
  assign o_val = i_neg ? -i_val : i_val;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, with pipeline stall
module muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic Clk,
  input logic Reset,
  muldiv_if.slave bus
);
  state_t             r_state, w_next;
  logic [1:0]         r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc, w_step, w_prod;
  logic [WIDTH-1:0]   r_opnd, r_hi, r_lo, w_abs_a, w_abs_b, w_quot, w_rem;
  logic [WIDTH:0]     w_sum, w_rsh, w_diff;
  logic               r_neg_lo, r_neg_hi, r_zero, r_busy, r_done, r_dbz;
  logic               w_signed, w_is_div, w_zero, w_last;

  assign w_signed = ~bus.Op[0];
  assign w_is_div = bus.Op[1];
  assign w_zero   = w_is_div && bus.OperandB == '0;
  assign w_last   = r_cnt == CNT_W'(WIDTH - 1);

  // Signed ops iterate on magnitudes; signs are reapplied at FIX.
  muldiv_sign_fix #(.W(WIDTH)) u_abs_a (.i_neg(w_signed & bus.OperandA[WIDTH-1]), .i_val(bus.OperandA), .o_val(w_abs_a));
  muldiv_sign_fix #(.W(WIDTH)) u_abs_b (.i_neg(w_signed & bus.OperandB[WIDTH-1]), .i_val(bus.OperandB), .o_val(w_abs_b));
  muldiv_sign_fix #(.W(2*WIDTH)) u_prod (.i_neg(r_neg_lo), .i_val(r_acc), .o_val(w_prod));
  muldiv_sign_fix #(.W(WIDTH)) u_quot (.i_neg(r_neg_lo), .i_val(r_acc[WIDTH-1:0]), .o_val(w_quot));
  muldiv_sign_fix #(.W(WIDTH)) u_rem (.i_neg(r_neg_hi), .i_val(r_acc[2*WIDTH-1:WIDTH]), .o_val(w_rem));

  // Multiply: add multiplicand into the high half when the multiplier LSB is set, then shift right.
  // Divide: shift {rem,quot} left, keep the trial subtraction when it does not borrow.
  assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_rsh  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff = w_rsh - {1'b0, r_opnd};
  assign w_step = r_op[1] ? (w_diff[WIDTH] ? {w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                           : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1})
                          : {w_sum, r_acc[WIDTH-1:1]};

  assign bus.ALUhi     = r_hi;
  assign bus.ALUlo     = r_lo;
  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;
  assign bus.DivByZero = r_dbz;
  assign bus.Stall     = r_busy & (bus.Start | bus.ReadHiLo | bus.HiWrite | bus.LoWrite);

  // State register.
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;

  // Next state: divide by zero skips straight to FIX.
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (bus.Start ? (w_zero ? FIX : RUN) : IDLE)
           : r_state == RUN  ? (w_last ? FIX : RUN)
           : IDLE;
  end

  // Datapath, HI/LO and status pulses.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_op <= '0; r_cnt <= '0; r_acc <= '0; r_opnd <= '0; r_hi <= '0; r_lo <= '0;
      r_neg_lo <= 1'b0; r_neg_hi <= 1'b0; r_zero <= 1'b0;
      r_busy <= 1'b0; r_done <= 1'b0; r_dbz <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.HiWrite) r_hi <= bus.WriteData;
        if (bus.LoWrite) r_lo <= bus.WriteData;
        if (bus.Start) begin
          r_op     <= bus.Op;
          r_cnt    <= '0;
          r_busy   <= 1'b1;
          r_zero   <= w_zero;
          r_neg_lo <= w_signed & (bus.OperandA[WIDTH-1] ^ bus.OperandB[WIDTH-1]);
          r_neg_hi <= w_signed & bus.OperandA[WIDTH-1];
          r_acc    <= {{WIDTH{1'b0}}, w_is_div ? w_abs_a : w_abs_b};
          r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
        end
      end else if (r_state == RUN) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_dbz  <= r_zero;
        if (!r_zero) {r_hi, r_lo} <= r_op[1] ? {w_rem, w_quot} : w_prod;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of multiply/divide results, latency, stall and reset
module tb_muldiv_unit;
  import muldiv_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   lat, bcnt;

  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_unit dut (.Clk(clk), .Reset(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int l, output int b);
    l = 0;
    b = bus.Busy ? 1 : 0;
    do begin
      tick();
      l++;
      if (bus.Busy) b++;
    end while (!bus.Done && l < 40);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int l, output int bc);
    bus.Start = 1'b1; bus.Op = op; bus.OperandA = a; bus.OperandB = b;
    tick();
    bus.Start = 1'b0;
    wait_done(l, bc);
  endtask

  initial begin
    bus.Start = 0; bus.Op = 0; bus.OperandA = 0; bus.OperandB = 0;
    bus.HiWrite = 0; bus.LoWrite = 0; bus.WriteData = 0; bus.ReadHiLo = 0;
    tick(); tick();
    check("rst_hi", bus.ALUhi, 0);
    check("rst_lo", bus.ALUlo, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    check("rst_dbz", bus.DivByZero, 0);
    rst_n = 1'b1;
    tick();

    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, lat, bcnt);
    check("mult_lat", lat, 33);
    check("mult_hi", bus.ALUhi, 32'hFFFFFFFF);
    check("mult_lo", bus.ALUlo, 32'hFFFFFFEB);
    check("mult_dbz", bus.DivByZero, 0);
    tick();
    check("mult_done_1cyc", bus.Done, 0);

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
    check("multu_busy33", bcnt, 33);
    check("multu_hi", bus.ALUhi, 32'hFFFFFFFE);
    check("multu_lo", bus.ALUlo, 32'h00000001);

    run_op(OP_MULT, 32'hFFFFFFFE, 32'hFFFFFFFD, lat, bcnt);
    check("mult_negneg", {bus.ALUhi, bus.ALUlo}, 64'd6);

    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, bcnt);
    check("div_lo", bus.ALUlo, 32'hFFFFFFFD);
    check("div_hi", bus.ALUhi, 32'hFFFFFFFF);
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bcnt);
    check("divu_b2b_lat", lat, 33);
    check("divu_lo", bus.ALUlo, 14);
    check("divu_hi", bus.ALUhi, 2);
    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, lat, bcnt);
    check("div_negb", {bus.ALUhi, bus.ALUlo}, {32'd1, 32'hFFFFFFFD});
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
    check("div_ovf", {bus.ALUhi, bus.ALUlo}, {32'd0, 32'h80000000});

    tick();
    bus.HiWrite = 1; bus.WriteData = 32'h1234;
    tick();
    bus.HiWrite = 0; bus.LoWrite = 1; bus.WriteData = 32'h5678;
    tick();
    bus.LoWrite = 0;
    check("mthi", bus.ALUhi, 32'h1234);
    check("mtlo", bus.ALUlo, 32'h5678);
    run_op(OP_DIVU, 32'd100, 32'd0, lat, bcnt);
    check("dbz_lat", lat, 1);
    check("dbz_done", bus.Done, 1);
    check("dbz_flag", bus.DivByZero, 1);
    check("dbz_hilo", {bus.ALUhi, bus.ALUlo}, {32'h1234, 32'h5678});
    tick();
    check("dbz_pulse", {bus.Done, bus.DivByZero}, 0);

    bus.Start = 1; bus.Op = OP_DIV; bus.OperandA = 32'd50; bus.OperandB = 32'd3;
    tick();
    bus.Op = OP_MULTU; bus.OperandA = 32'd9; bus.OperandB = 32'd9;
    bus.ReadHiLo = 1; bus.HiWrite = 1; bus.WriteData = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      check("stall_busy", bus.Stall, 1);
      tick();
    end
    bus.Start = 0; bus.ReadHiLo = 0; bus.HiWrite = 0;
    #1;
    check("stall_idle_req", bus.Stall, 0);
    wait_done(lat, bcnt);
    check("stall_lo", bus.ALUlo, 16);
    check("stall_hi", bus.ALUhi, 2);
    tick();
    check("stall_no_2nd", bus.Busy, 0);
    bus.ReadHiLo = 1;
    #1;
    check("stall_after", bus.Stall, 0);
    bus.ReadHiLo = 0;

    bus.Start = 1; bus.Op = OP_MULT; bus.OperandA = 32'd5; bus.OperandB = 32'd5;
    tick();
    bus.Start = 0;
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus.Busy, 0);
    check("arst_hilo", {bus.ALUhi, bus.ALUlo}, 0);
    tick(); tick();
    #2;
    rst_n = 1'b1;
    tick();
    run_op(OP_MULT, 32'd2, 32'd3, lat, bcnt);
    check("post_rst_lat", lat, 33);
    check("post_rst_res", {bus.ALUhi, bus.ALUlo}, 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
